uart_cmd_responder: RTL
=======================

# uart_cmd_responder

Sensor-side command endpoint for the UART link: consumes bytes from the UART receiver, parses request frames from the host, executes register reads/writes against a small sensor/config register map, and streams a response frame back through the UART transmitter. It sits between `uart_top`'s RX outputs (`rx_data`/`rx_valid`) and TX inputs (`tx_start`/`tx_data`/`tx_busy`/`tx_done`). It is the responding end of the protocol that the host or testbench initiates.

## Interface
- `TIMEOUT_CYCLES`, default 200_000: maximum idle clocks between request bytes before a partial frame is abandoned.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte from the UART RX.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_start`  out  1  one-cycle request to the UART TX.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until `tx_done`.
- `tx_busy`  in  1  UART TX is busy.
- `tx_done`  in  1  one-cycle strobe at the end of the TX stop bit.
- `sensor_data`  in  16  sensor sample.
- `sensor_valid`  in  1  one-cycle strobe; captures `sensor_data`.
- `cfg`  out  64  config registers 0x8–0xF, flattened; reg 0x8 occupies bits [7:0].
- `busy`  out  1  high in every state except IDLE.
- `frame_err_cnt`  out  8  saturating count of bad or aborted frames.

## Operation
- Request frame: `0xA5`, CMD, ADDR, [DATA, write only], CHK.
  - CHK is the XOR of CMD, ADDR and DATA (DATA only when present).
  - CMD `0x01` is read; CMD `0x02` is write.
- Response frame: `0x5A`, STATUS, RDATA, CHK.
  - CHK = STATUS ^ RDATA.
  - RDATA is the read value, or the written value on a successful write, otherwise `0x00`.
- STATUS codes:
  - `0x00` OK.
  - `0x01` bad checksum.
  - `0x02` bad CMD.
  - `0x03` bad or read-only address.
- Register map:
  - 0x0 = sample[7:0], 0x1 = sample[15:8].
  - 0x2 = 8-bit sample counter; wraps 0xFF→0x00.
  - 0x3 = ID, constant `0x51`.
  - 0x4–0x7 are invalid.
  - 0x8–0xF are read/write config.
  - Addresses ≥ 0x10 are invalid.
  - A write to 0x0–0x7 returns STATUS `0x03`.
- Checksum is validated first; a bad CHK gives `0x01` regardless of CMD or ADDR. CMD is validated next, then ADDR.
- The CMD byte determines whether a DATA byte is expected. An unknown CMD expects no DATA.
- States and transitions:
  - IDLE → SYNC matched (`rx_valid` with `0xA5`) → CMD → ADDR → DATA (write only) → CHK → EXEC → TX_LOAD ↔ TX_WAIT → IDLE.
  - In IDLE, non-`0xA5` bytes are discarded silently.
- Sensor capture: `sensor_valid` updates 0x0, 0x1 and 0x2 in any state, including during EXEC.
  - A read of the same register in the same EXEC cycle returns the pre-update value.
- `frame_err_cnt` increments on STATUS ≠ 0 and on timeout; it holds at 0xFF.

## Timing
- Reset values:
  - `tx_start` = 0, `tx_data` = 0x00, `busy` = 0, `frame_err_cnt` = 0.
  - `cfg` = all zero; sample regs and counter = 0.
  - State = IDLE.
- Reset mid-frame or mid-response: abandon immediately. No further `tx_start` is issued; `tx_data` returns to 0x00.
- Latency: CHK byte accepted in cycle N.
  - EXEC in N+1; the register write commits at the end of N+1.
  - TX_LOAD in N+2; `tx_start` is pulsed in N+2 if `tx_busy` = 0, otherwise in the first later cycle with `tx_busy` = 0.
- TX handshake per byte:
  - TX_LOAD drives `tx_data` and a one-cycle `tx_start`, then moves to TX_WAIT.
  - TX_WAIT waits for `tx_done`, then goes to TX_LOAD for the next byte, or to IDLE after byte 4.
- `rx_valid` seen in EXEC, TX_LOAD or TX_WAIT is dropped. This case is not counted as an error.
- Timeout:
  - The inter-byte counter resets on every accepted byte while in CMD, ADDR, DATA or CHK.
  - When it reaches `TIMEOUT_CYCLES` with no byte: go to IDLE with no response, and increment `frame_err_cnt`.
- `rx_valid` in the same cycle as a timeout: the byte wins and the counter resets.

## Structure
- Package `uart_cmd_pkg` holds:
  - the state enum;
  - the `SYNC_REQ` (0xA5) and `SYNC_RSP` (0x5A) constants;
  - the CMD codes and STATUS codes;
  - the address constants and ID value.
- One sub-module, `uart_cmd_regfile`, holds:
  - the sample, counter and config registers;
  - the read mux;
  - address and write-permission checks, returning a status.
- The top level contains the parser FSM, checksum, timeout counter and TX sequencer.

## Test plan
- Write then read:
  - Send A5 02 08 3C 36 → expect 5A 00 3C 3C; `cfg[7:0]` = 0x3C.
  - Then send A5 01 08 09 → expect 5A 00 3C 3C.
- ID read: send A5 01 03 02 → expect 5A 00 51 51.
- Sensor read: drive `sensor_data` = 0xBEEF with `sensor_valid` twice, then read 0x1 → expect 5A 00 BE BE; a read of 0x2 returns 0x02.
- Errors:
  - A5 01 08 00 → 5A 01 00 01.
  - A5 02 00 11 13 → 5A 03 00 03.
  - A5 07 08 0F → 5A 02 00 02.
  - `frame_err_cnt` = 3 after these three frames.
- Timeout: send A5 01, then idle for `TIMEOUT_CYCLES` + 10 cycles → no `tx_start`; `frame_err_cnt` +1. The next valid frame is answered normally.
- Reset and overlap:
  - Assert `rst` during response byte 2 → no further `tx_start`; outputs at reset values.
  - Bytes injected during TX_WAIT are ignored, and the response bytes are unchanged.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command responder: parser states,
// frame sync bytes, command/status codes and the register map layout.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC,
        ST_TX_LOAD,
        ST_TX_WAIT
    } state_t;

    localparam logic [7:0] SYNC_REQ        = 8'hA5;
    localparam logic [7:0] SYNC_RSP        = 8'h5A;

    localparam logic [7:0] CMD_READ        = 8'h01;
    localparam logic [7:0] CMD_WRITE       = 8'h02;

    localparam logic [7:0] STATUS_OK       = 8'h00;
    localparam logic [7:0] STATUS_BAD_CHK  = 8'h01;
    localparam logic [7:0] STATUS_BAD_CMD  = 8'h02;
    localparam logic [7:0] STATUS_BAD_ADDR = 8'h03;

    localparam logic [7:0] ADDR_SAMPLE_LO  = 8'h00;
    localparam logic [7:0] ADDR_SAMPLE_HI  = 8'h01;
    localparam logic [7:0] ADDR_COUNT      = 8'h02;
    localparam logic [7:0] ADDR_ID         = 8'h03;
    localparam logic [7:0] ADDR_CFG_FIRST  = 8'h08;
    localparam logic [7:0] ADDR_CFG_LAST   = 8'h0F;

    localparam logic [7:0] ID_VALUE        = 8'h51;

    localparam int         RSP_LEN         = 4;

    // True for the eight read/write config registers 0x08..0x0F.
    function automatic logic isCfgAddr(input logic [7:0] addr);
        return (addr >= ADDR_CFG_FIRST) && (addr <= ADDR_CFG_LAST);
    endfunction

    // Increment that sticks at 0xFF instead of wrapping.
    function automatic logic [7:0] satInc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte-level handshake between the UART core (RX strobe, TX start/busy/done)
// and the command responder. The UART side is the master, the responder the slave.
interface uart_cmd_responder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output rx_data, rx_valid, tx_busy, tx_done,
        input  tx_start, tx_data
    );

    modport slave (
        input  rx_data, rx_valid, tx_busy, tx_done,
        output tx_start, tx_data
    );

endinterface

// File: rtl/uart_cmd_regfile.sv
// Sensor/config register file: live sensor sample, sample counter, fixed ID
// and eight writable config bytes, plus the read mux and access checks.
module uart_cmd_regfile
    import uart_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_sensor_data,
    input  logic        i_sensor_valid,
    input  logic [7:0]  i_addr,
    input  logic        i_is_write,
    input  logic        i_wr_en,
    input  logic [7:0]  i_wr_data,
    output logic [7:0]  o_rd_data,
    output logic [7:0]  o_status,
    output logic [63:0] o_cfg
);

    logic [15:0]     r_sample;
    logic [7:0]      r_count;
    logic [7:0][7:0] r_cfg;

    assign o_cfg = r_cfg;

    // Capture every sensor strobe and count it, independent of the parser state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
            r_count  <= '0;
        end else if (i_sensor_valid) begin
            r_sample <= i_sensor_data;
            r_count  <= r_count + 8'd1;
        end
    end

    // Config bytes change only on an approved write from the parser.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= '0;
        end else if (i_wr_en && isCfgAddr(i_addr)) begin
            r_cfg[i_addr[2:0]] <= i_wr_data;
        end
    end

    // Read mux works off the current register contents, so a sensor update in
    // the same cycle is not yet visible.
    always_comb begin
        o_rd_data = 8'h00;
        case (i_addr)
            ADDR_SAMPLE_LO: o_rd_data = r_sample[7:0];
            ADDR_SAMPLE_HI: o_rd_data = r_sample[15:8];
            ADDR_COUNT:     o_rd_data = r_count;
            ADDR_ID:        o_rd_data = ID_VALUE;
            default: begin
                if (isCfgAddr(i_addr)) begin
                    o_rd_data = r_cfg[i_addr[2:0]];
                end
            end
        endcase
    end

    // Reads may target 0x00..0x03 or the config window; writes only the config window.
    always_comb begin
        o_status = STATUS_OK;
        if (i_is_write) begin
            if (!isCfgAddr(i_addr)) begin
                o_status = STATUS_BAD_ADDR;
            end
        end else if (!((i_addr <= ADDR_ID) || isCfgAddr(i_addr))) begin
            o_status = STATUS_BAD_ADDR;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Sensor-side command endpoint: parses A5-framed requests from the UART RX,
// runs the register access and streams a 4-byte 5A-framed response to the TX.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_responder_if.slave  bus,
    input  logic [15:0]          i_sensor_data,
    input  logic                 i_sensor_valid,
    output logic [63:0]          o_cfg,
    output logic                 o_busy,
    output logic [7:0]           o_frame_err_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    logic [7:0]    r_cmd;
    logic [7:0]    r_addr;
    logic [7:0]    r_data;
    logic [7:0]    r_chkAcc;
    logic          r_chkOk;
    logic [7:0]    r_status;
    logic [7:0]    r_rdata;
    logic [7:0]    r_txData;
    logic [1:0]    r_byteIdx;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_errCnt;

    logic          w_isWrite;
    logic          w_cmdOk;
    logic [7:0]    w_regRdData;
    logic [7:0]    w_regStatus;
    logic [7:0]    w_execStatus;
    logic [7:0]    w_execRdata;
    logic          w_wrEn;

    assign w_isWrite = (r_cmd == CMD_WRITE);
    assign w_cmdOk   = (r_cmd == CMD_READ) || (r_cmd == CMD_WRITE);
    assign w_wrEn    = (r_state == ST_EXEC) && (w_execStatus == STATUS_OK) && w_isWrite;

    // tx_start follows tx_busy in the same cycle so the first free cycle in
    // TX_LOAD launches the byte without an extra clock of delay.
    assign bus.tx_start    = (r_state == ST_TX_LOAD) && !bus.tx_busy;
    assign bus.tx_data     = r_txData;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_frame_err_cnt = r_errCnt;

    uart_cmd_regfile u_regfile (
        .clk            (clk),
        .rst            (rst),
        .i_sensor_data  (i_sensor_data),
        .i_sensor_valid (i_sensor_valid),
        .i_addr         (r_addr),
        .i_is_write     (w_isWrite),
        .i_wr_en        (w_wrEn),
        .i_wr_data      (r_data),
        .o_rd_data      (w_regRdData),
        .o_status       (w_regStatus),
        .o_cfg          (o_cfg)
    );

    // Priority of checks: checksum, then command, then address/permission.
    always_comb begin
        w_execStatus = STATUS_OK;
        w_execRdata  = 8'h00;
        if (!r_chkOk) begin
            w_execStatus = STATUS_BAD_CHK;
        end else if (!w_cmdOk) begin
            w_execStatus = STATUS_BAD_CMD;
        end else if (w_regStatus != STATUS_OK) begin
            w_execStatus = w_regStatus;
        end else begin
            w_execRdata = w_isWrite ? r_data : w_regRdData;
        end
    end

    // Response byte selector: sync, status, data, checksum.
    function automatic logic [7:0] rspByte(input logic [1:0] idx,
                                           input logic [7:0] status,
                                           input logic [7:0] rdata);
        case (idx)
            2'd0:    return SYNC_RSP;
            2'd1:    return status;
            2'd2:    return rdata;
            default: return status ^ rdata;
        endcase
    endfunction

    // Parser, executor and TX sequencer in one state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_chkAcc  <= '0;
            r_chkOk   <= 1'b0;
            r_status  <= '0;
            r_rdata   <= '0;
            r_txData  <= '0;
            r_byteIdx <= '0;
            r_timer   <= '0;
            r_errCnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer  <= '0;
                    r_chkAcc <= '0;
                    if (bus.rx_valid && (bus.rx_data == SYNC_REQ)) begin
                        r_state <= ST_CMD;
                    end
                end

                ST_CMD, ST_ADDR, ST_DATA, ST_CHK: begin
                    if (bus.rx_valid) begin
                        r_timer <= '0;
                        case (r_state)
                            ST_CMD: begin
                                r_cmd    <= bus.rx_data;
                                r_chkAcc <= bus.rx_data;
                                r_state  <= ST_ADDR;
                            end
                            ST_ADDR: begin
                                r_addr   <= bus.rx_data;
                                r_chkAcc <= r_chkAcc ^ bus.rx_data;
                                r_state  <= (r_cmd == CMD_WRITE) ? ST_DATA : ST_CHK;
                            end
                            ST_DATA: begin
                                r_data   <= bus.rx_data;
                                r_chkAcc <= r_chkAcc ^ bus.rx_data;
                                r_state  <= ST_CHK;
                            end
                            default: begin
                                r_chkOk <= (bus.rx_data == r_chkAcc);
                                r_state <= ST_EXEC;
                            end
                        endcase
                    end else if (r_timer == TIMER_LAST) begin
                        r_state  <= ST_IDLE;
                        r_errCnt <= satInc(r_errCnt);
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                ST_EXEC: begin
                    r_status  <= w_execStatus;
                    r_rdata   <= w_execRdata;
                    r_byteIdx <= 2'd0;
                    r_txData  <= SYNC_RSP;
                    r_state   <= ST_TX_LOAD;
                    if (w_execStatus != STATUS_OK) begin
                        r_errCnt <= satInc(r_errCnt);
                    end
                end

                ST_TX_LOAD: begin
                    if (!bus.tx_busy) begin
                        r_state <= ST_TX_WAIT;
                    end
                end

                ST_TX_WAIT: begin
                    if (bus.tx_done) begin
                        if (r_byteIdx == 2'(RSP_LEN - 1)) begin
                            r_txData <= 8'h00;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_byteIdx <= r_byteIdx + 2'd1;
                            r_txData  <= rspByte(r_byteIdx + 2'd1, r_status, r_rdata);
                            r_state   <= ST_TX_LOAD;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
